// File: rtl/shift_issue_stage.sv
// Issue stage in front of the 32-bit shifter: decodes the six MIPS shift functs,
// forms {a, b, op, rd} and buffers them in a two-entry queue; other instructions are dropped.
module shift_issue_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs_val,
  input  logic [31:0]      in_rt_val,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [1:0]       out_op,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       dbg_state
);

  // The state encoding doubles as the queue occupancy.
  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = FULL_CNT
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  amt;
    logic [1:0]  op;
    logic [4:0]  rd;
  } entry_t;

  state_t           r_state;
  state_t           w_next;
  entry_t           r_head;
  entry_t           r_tail;
  entry_t           w_new;
  logic [CNT_W-1:0] r_drop;
  logic             w_legal;
  logic [4:0]       w_amt;
  logic [1:0]       w_op;
  logic             w_acc;
  logic             w_push;
  logic             w_pop;
  logic             w_unused;

  assign w_unused = ^{in_rs_val[31:5], in_instr[25:16]};

  always_comb begin
    w_legal = 1'b0;
    w_amt   = in_instr[10:6];
    w_op    = 2'b00;
    if (in_instr[31:26] == 6'd0) begin
      case (in_instr[5:0])
        6'b000000: w_legal = 1'b1;
        6'b000010: begin w_legal = 1'b1; w_op = 2'b01; end
        6'b000011: begin w_legal = 1'b1; w_op = 2'b11; end
        6'b000100: begin w_legal = 1'b1; w_amt = in_rs_val[4:0]; end
        6'b000110: begin w_legal = 1'b1; w_amt = in_rs_val[4:0]; w_op = 2'b01; end
        6'b000111: begin w_legal = 1'b1; w_amt = in_rs_val[4:0]; w_op = 2'b11; end
        default:   w_legal = 1'b0;
      endcase
    end
  end

  // Handshake: a transfer happens on an edge where valid && ready are both high;
  // in_ready depends on queue state only, and flush cancels both transfers.
  assign w_acc  = in_valid && in_ready && !flush;
  assign w_push = w_acc && w_legal;
  assign w_pop  = out_valid && out_ready && !flush;
  assign w_new  = '{a: in_rt_val, amt: w_amt, op: w_op, rd: in_instr[15:11]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_push) w_next = ONE;
        ONE: begin
          if (w_push && !w_pop)      w_next = FULL;
          else if (w_pop && !w_push) w_next = EMPTY;
        end
        FULL:    if (w_pop) w_next = ONE;
        default: w_next = EMPTY;
      endcase
    end
  end

  // Vacated slots are zeroed so the head reads as all-zero whenever the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_push) r_head <= w_new;
        ONE: begin
          if (w_push && w_pop) r_head <= w_new;
          else if (w_push)     r_tail <= w_new;
          else if (w_pop)      r_head <= '0;
        end
        FULL: begin
          if (w_pop) begin
            r_head <= r_tail;
            r_tail <= '0;
          end
        end
        default: begin
          r_head <= '0;
          r_tail <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_drop <= '0;
    else if (w_acc && !w_legal && r_drop != '1) r_drop <= r_drop + 1'b1;
  end

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_a     = r_head.a;
  assign out_b     = {21'b0, r_head.amt, 6'b0};
  assign out_op    = r_head.op;
  assign out_rd    = r_head.rd;
  assign drop_cnt  = r_drop;
  assign dbg_state = r_state;

endmodule
